id_ex_stage: RTL and testbench

ID/EX pipeline stage of the segmented core: registers decoded instruction fields, derives the 4-bit ALU operation code, resolves register forwarding from EX/MEM and MEM/WB, and presents final operands to the ALU. It also flags load-use hazards to the decode stage. It sits between the register-file/decode stage and the ALU.

---
 rtl/ex_pkg.sv | 65 ++++++
 rtl/alu_ctrl_dec.sv | 58 +++++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: opcodes, ALU operation codes and the decoded
// control bundle carried from the decoder into the ID/EX stage.
package ex_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLTU = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   illegal;
    a_sel_e a_sel;
    b_sel_e b_sel;
  } ex_ctrl_t;

  // alt selects the SUB/SRA flavour for funct3 000/101
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU operation
// code and the EX control bundle. Validity gating is left to the stage.
module alu_ctrl_dec
  import ex_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op,
  output ex_ctrl_t   ctrl
);

  always_comb begin
    alu_op        = ALU_ADD;
    ctrl.regwrite = 1'b0;
    ctrl.memread  = 1'b0;
    ctrl.memwrite = 1'b0;
    ctrl.illegal  = 1'b0;
    ctrl.a_sel    = A_RS1;
    ctrl.b_sel    = B_IMM;
    case (opcode)
      OP_RTYPE: begin
        alu_op        = f3_to_op(funct3, funct7_5);
        ctrl.regwrite = 1'b1;
        ctrl.b_sel    = B_RS2;
      end
      // Immediate ADDI has no SUB form, so funct7[5] only matters for shifts.
      OP_IALU: begin
        alu_op        = f3_to_op(funct3, funct7_5 & (funct3 == 3'b101));
        ctrl.regwrite = 1'b1;
      end
      OP_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
      end
      OP_STORE: ctrl.memwrite = 1'b1;
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.a_sel    = A_ZERO;
      end
      OP_AUIPC: begin
        ctrl.regwrite = 1'b1;
        ctrl.a_sel    = A_PC;
      end
      OP_JAL, OP_JALR: begin
        ctrl.regwrite = 1'b1;
        ctrl.a_sel    = A_PC;
        ctrl.b_sel    = B_FOUR;
      end
      OP_BRANCH: begin
        alu_op     = ALU_SUB;
        ctrl.b_sel = B_RS2;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// ALU operand selection and load-use hazard detection toward decode.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_illegal,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard
);

  logic            vld_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0]      rs1a_q, rs2a_q, rd_q;
  logic [6:0]      opc_q;
  logic [2:0]      f3_q;
  logic            f75_q;

  // Flush clears every field so a bubble presents all-zero state downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      rs1a_q <= '0;
      rs2a_q <= '0;
      rd_q   <= '0;
      opc_q  <= '0;
      f3_q   <= '0;
      f75_q  <= 1'b0;
    end else if (!stall) begin
      vld_q  <= in_valid;
      pc_q   <= in_pc;
      rs1_q  <= in_rs1_data;
      rs2_q  <= in_rs2_data;
      imm_q  <= in_imm;
      rs1a_q <= in_rs1_addr;
      rs2a_q <= in_rs2_addr;
      rd_q   <= in_rd_addr;
      opc_q  <= in_opcode;
      f3_q   <= in_funct3;
      f75_q  <= in_funct7_5;
    end
  end

  alu_op_e  dec_op;
  ex_ctrl_t dec_ctrl;

  alu_ctrl_dec u_dec (
    .opcode   (opc_q),
    .funct3   (f3_q),
    .funct7_5 (f75_q),
    .alu_op   (dec_op),
    .ctrl     (dec_ctrl)
  );

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, b_pre;

  // EX/MEM is younger than MEM/WB, so it wins when both target the register.
  always_comb begin
    rs1_fwd = rs1_q;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs1a_q)
      rs1_fwd = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs1a_q)
      rs1_fwd = memwb_result;

    rs2_fwd = rs2_q;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs2a_q)
      rs2_fwd = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs2a_q)
      rs2_fwd = memwb_result;
  end

  always_comb begin
    case (dec_ctrl.a_sel)
      A_PC:    alu_a = pc_q;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_fwd;
    endcase

    case (dec_ctrl.b_sel)
      B_RS2:   b_pre = rs2_fwd;
      B_FOUR:  b_pre = XLEN'(4);
      default: b_pre = imm_q;
    endcase

    // Shifts only consume the low five bits of the amount.
    if (dec_op == ALU_SLL || dec_op == ALU_SRL || dec_op == ALU_SRA)
      alu_b = XLEN'(b_pre[4:0]);
    else
      alu_b = b_pre;
  end

  assign alu_op        = dec_op;
  assign ex_valid      = vld_q;
  assign ex_regwrite   = vld_q & dec_ctrl.regwrite;
  assign ex_memread    = vld_q & dec_ctrl.memread;
  assign ex_memwrite   = vld_q & dec_ctrl.memwrite;
  assign ex_illegal    = vld_q & dec_ctrl.illegal;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign ex_store_data = rs2_fwd;

  assign load_use_hazard = ex_valid & ex_memread & (rd_q != 5'd0) &
                           ((rd_q == in_rs1_addr) | (rd_q == in_rs2_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_id_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
  logic [4:0]  ex_rd;
  logic        load_use_hazard;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rs1_addr(in_rs1_addr),
    .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a, b, pc, sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        v, rw, mr, mw, ill, hz;
  } vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  vec_t  mon_e, mon_a;
  string mon_n;

  function automatic string fmt(input vec_t x);
    return $sformatf("a=%h b=%h op=%h v=%b rw=%b mr=%b mw=%b ill=%b rd=%0d pc=%h sd=%h hz=%b",
                     x.a, x.b, x.op, x.v, x.rw, x.mr, x.mw, x.ill, x.rd, x.pc, x.sd, x.hz);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a.a  = alu_a;       mon_a.b  = alu_b;      mon_a.pc = ex_pc;
      mon_a.sd = ex_store_data; mon_a.op = alu_op;   mon_a.rd = ex_rd;
      mon_a.v  = ex_valid;    mon_a.rw = ex_regwrite; mon_a.mr = ex_memread;
      mon_a.mw = ex_memwrite; mon_a.ill = ex_illegal; mon_a.hz = load_use_hazard;
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL %s: got %s | want %s", mon_n, fmt(mon_a), fmt(mon_e));
      end
    end
  end

  task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                     input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
                     input logic [4:0] rd, input logic [31:0] imm, input logic [6:0] opc,
                     input logic [2:0] f3, input logic f75);
    in_valid = v; in_pc = pc; in_rs1_addr = r1; in_rs1_data = d1;
    in_rs2_addr = r2; in_rs2_data = d2; in_rd_addr = rd; in_imm = imm;
    in_opcode = opc; in_funct3 = f3; in_funct7_5 = f75;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                     input logic mw, input logic [4:0] mr, input logic [31:0] md);
    exmem_regwrite = ew; exmem_rd = er; exmem_result = ed;
    memwb_regwrite = mw; memwb_rd = mr; memwb_result = md;
  endtask

  task automatic expv(input string n, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic v, input logic rw, input logic mr,
                      input logic mw, input logic ill, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [31:0] sd, input logic hz);
    vec_t e;
    e.a = a; e.b = b; e.op = op; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw;
    e.ill = ill; e.rd = rd; e.pc = pc; e.sd = sd; e.hz = hz;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
    fwd(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 7'd0, 3'd0, 1'b0);
    fwd(0, 0, 0, 0, 0, 0);
    #1 expv("reset", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    to_neg(); drv(1, 32'h100, 5, 10, 6, 3, 7, 0, OP_RTYPE, 3'b000, 1);
    to_pos(); expv("sub", 10, 3, 4'h8, 1, 1, 0, 0, 0, 7, 32'h100, 3, 0);

    to_neg(); drv(1, 32'h104, 1, 32'h8000_0000, 0, 0, 2, 32'h423, OP_IALU, 3'b101, 1);
    to_pos(); expv("srai", 32'h8000_0000, 3, 4'hD, 1, 1, 0, 0, 0, 2, 32'h104, 0, 0);

    to_neg(); drv(1, 32'h108, 7, 32'h1111, 8, 32'h22, 9, 0, OP_RTYPE, 3'b000, 0);
    to_pos(); fwd(1, 7, 32'hAAAA, 1, 7, 32'h5555);
    expv("fwd_exmem_wins", 32'hAAAA, 32'h22, 4'h0, 1, 1, 0, 0, 0, 9, 32'h108, 32'h22, 0);

    to_neg(); drv(1, 32'h10C, 0, 32'h1111, 8, 32'h22, 9, 0, OP_RTYPE, 3'b000, 0);
    to_pos(); fwd(1, 0, 32'hAAAA, 1, 0, 32'h5555);
    expv("fwd_x0", 32'h1111, 32'h22, 4'h0, 1, 1, 0, 0, 0, 9, 32'h10C, 32'h22, 0);

    to_neg(); drv(1, 32'h110, 7, 1, 8, 2, 9, 0, OP_RTYPE, 3'b000, 0);
    to_pos(); fwd(0, 7, 32'hAAAA, 1, 8, 32'h5555);
    expv("fwd_memwb", 1, 32'h5555, 4'h0, 1, 1, 0, 0, 0, 9, 32'h110, 32'h5555, 0);

    to_neg(); drv(1, 32'h114, 2, 32'h1000, 0, 0, 4, 8, OP_LOAD, 3'b010, 0);
    to_pos(); in_rs1_addr = 3; in_rs2_addr = 4;
    expv("lw_hazard", 32'h1000, 8, 4'h0, 1, 1, 1, 0, 0, 4, 32'h114, 0, 1);

    to_neg(); drv(1, 32'h118, 2, 32'h1000, 0, 0, 0, 8, OP_LOAD, 3'b010, 0);
    to_pos(); in_rs1_addr = 0; in_rs2_addr = 0;
    expv("lw_x0_no_hazard", 32'h1000, 8, 4'h0, 1, 1, 1, 0, 0, 0, 32'h118, 0, 0);

    to_neg(); drv(1, 32'h11C, 2, 32'h2000, 9, 32'h1234, 0, 32'hFFFF_FFFC, OP_STORE, 3'b010, 0);
    to_pos(); fwd(1, 9, 32'hBEEF, 0, 0, 0);
    expv("sw_fwd", 32'h2000, 32'hFFFF_FFFC, 4'h0, 1, 0, 0, 1, 0, 0, 32'h11C, 32'hBEEF, 0);

    to_neg(); drv(1, 32'h120, 3, 5, 4, 6, 0, 32'h10, OP_BRANCH, 3'b000, 0);
    to_pos(); expv("beq", 5, 6, 4'h8, 1, 0, 0, 0, 0, 0, 32'h120, 6, 0);

    to_neg(); drv(1, 32'h124, 0, 0, 0, 0, 1, 32'h40, OP_JAL, 3'b000, 0);
    to_pos(); expv("jal", 32'h124, 4, 4'h0, 1, 1, 0, 0, 0, 1, 32'h124, 0, 0);

    to_neg(); drv(1, 32'h128, 3, 32'h77, 0, 0, 5, 32'h1234_5000, OP_LUI, 3'b000, 0);
    to_pos(); expv("lui", 0, 32'h1234_5000, 4'h0, 1, 1, 0, 0, 0, 5, 32'h128, 0, 0);

    to_neg(); drv(1, 32'h12C, 0, 0, 0, 0, 6, 32'h1000, OP_AUIPC, 3'b000, 0);
    to_pos(); expv("auipc", 32'h12C, 32'h1000, 4'h0, 1, 1, 0, 0, 0, 6, 32'h12C, 0, 0);

    to_neg(); drv(1, 32'h130, 1, 1, 2, 32'hFFFF_FF25, 3, 0, OP_RTYPE, 3'b001, 0);
    to_pos(); expv("sll_mask", 1, 5, 4'h1, 1, 1, 0, 0, 0, 3, 32'h130, 32'hFFFF_FF25, 0);

    to_neg(); drv(1, 32'h134, 1, 3, 0, 0, 2, 32'h400, OP_IALU, 3'b000, 1);
    to_pos(); expv("addi_f75", 3, 32'h400, 4'h0, 1, 1, 0, 0, 0, 2, 32'h134, 0, 0);

    to_neg(); drv(1, 32'h138, 1, 9, 2, 8, 3, 0, OP_RTYPE, 3'b011, 0);
    to_pos(); expv("sltu", 9, 8, 4'h2, 1, 1, 0, 0, 0, 3, 32'h138, 8, 0);

    to_neg(); drv(0, 32'h13C, 1, 9, 2, 8, 3, 0, OP_RTYPE, 3'b000, 0);
    to_pos(); expv("invalid_gated", 9, 8, 4'h0, 0, 0, 0, 0, 0, 3, 32'h13C, 8, 0);

    to_neg(); drv(1, 32'h600, 1, 1, 2, 2, 3, 0, OP_RTYPE, 3'b000, 0);
    to_pos(); expv("pre_stall", 1, 2, 4'h0, 1, 1, 0, 0, 0, 3, 32'h600, 2, 0);

    to_neg(); stall = 1'b1; drv(1, 32'h700, 4, 32'h44, 5, 32'h55, 6, 0, OP_RTYPE, 3'b000, 1);
    for (int i = 0; i < 3; i++) begin
      to_pos(); expv($sformatf("stall_hold%0d", i), 1, 2, 4'h0, 1, 1, 0, 0, 0, 3, 32'h600, 2, 0);
      to_neg();
    end

    flush = 1'b1;
    to_pos(); expv("stall_flush", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); stall = 1'b0; flush = 1'b0;

    drv(1, 32'h500, 1, 32'h11, 2, 32'h22, 3, 32'h33, 7'b1111111, 3'b000, 0);
    to_pos(); expv("illegal", 32'h11, 32'h33, 4'h0, 1, 0, 0, 0, 1, 3, 32'h500, 32'h22, 0);

    // rst_n drops after the edge; only an asynchronous clear shows zeros at the negedge.
    to_pos(); rst_n = 1'b0;
    expv("async_reset", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); rst_n = 1'b1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
